// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int unsigned MEM_LAT_MIN  = 1;
    localparam int unsigned MEM_LAT_MAX  = 4;
    localparam int unsigned MAX_HOLD_MIN = 1;
    localparam int unsigned MAX_HOLD_MAX = 15;

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way pick: one-hot grant from a request pair and a tie-break pointer.
module arb_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / debug) arbiter in front of a single fixed-latency memory.
// Define MEM_ARB_RR_EN for round-robin tie-break in IDLE; otherwise port 0 has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              ack0_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic              gnt1_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
        $error("mem_arbiter: MEM_LAT out of range");
    end
    if (MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_max_hold
        $error("mem_arbiter: MAX_HOLD out of range");
    end

    localparam logic [1:0]        LAT_LOAD   = 2'(MEM_LAT - 1);
    localparam logic [3:0]        HOLD_LIMIT = 4'(MAX_HOLD);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t      state;
    logic        owner;
    logic        we_q;
    logic [1:0]  wait_cnt;
    logic [3:0]  hold_cnt;
    logic        rr_ptr;
    logic [1:0]  pick_gnt;

    logic              same_req;
    logic              other_req;
    logic              stay;
    logic              swap;
    logic              next_owner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifndef MEM_ARB_RR_EN
    assign rr_ptr = PORT_CPU;
`endif

    arb_pick u_pick (
        .req (({req1_i, req0_i})),
        .ptr (rr_ptr),
        .gnt (pick_gnt)
    );

    // Holder keeps the bus while under its quota, or indefinitely if the other side is idle.
    always_comb begin
        same_req   = owner ? req1_i : req0_i;
        other_req  = owner ? req0_i : req1_i;
        stay       = same_req && ((hold_cnt < HOLD_LIMIT) || !other_req);
        swap       = !stay && other_req;
        next_owner = owner;
        if (state == IDLE) begin
            next_owner = pick_gnt[1];
        end else if (!stay) begin
            next_owner = ~owner;
        end
        sel_we    = next_owner ? we1_i    : we0_i;
        sel_addr  = next_owner ? addr1_i  : addr0_i;
        sel_wdata = next_owner ? wdata1_i : wdata0_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            owner       <= PORT_CPU;
            we_q        <= 1'b0;
            wait_cnt    <= '0;
            hold_cnt    <= '0;
            gnt0_o      <= 1'b0;
            gnt1_o      <= 1'b0;
            ack0_o      <= 1'b0;
            ack1_o      <= 1'b0;
            rdata0_o    <= '0;
            rdata1_o    <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr      <= PORT_CPU;
`endif
        end else begin
            ack0_o <= 1'b0;
            ack1_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_i || req1_i) begin
                        state       <= ISSUE;
                        owner       <= next_owner;
                        gnt0_o      <= pick_gnt[0];
                        gnt1_o      <= pick_gnt[1];
                        we_q        <= sel_we;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= sel_we;
                        mem_addr_o  <= sel_addr & ALIGN_MASK;
                        mem_wdata_o <= sel_wdata;
                        hold_cnt    <= 4'd1;
`ifdef MEM_ARB_RR_EN
                        rr_ptr      <= pick_gnt[0];
`endif
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    mem_en_o <= 1'b0;
                    mem_we_o <= 1'b0;
                    wait_cnt <= LAT_LOAD;
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state  <= RESP;
                        ack0_o <= ~owner;
                        ack1_o <= owner;
                        if (!we_q) begin
                            if (owner) rdata1_o <= mem_rdata_i;
                            else       rdata0_o <= mem_rdata_i;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (stay || swap) begin
                        state       <= ISSUE;
                        owner       <= next_owner;
                        gnt0_o      <= ~next_owner;
                        gnt1_o      <= next_owner;
                        we_q        <= sel_we;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= sel_we;
                        mem_addr_o  <= sel_addr & ALIGN_MASK;
                        mem_wdata_o <= sel_wdata;
                        if (swap) begin
                            hold_cnt <= 4'd1;
                        end else if (hold_cnt != 4'hF) begin
                            hold_cnt <= hold_cnt + 4'd1;
                        end
                    end else begin
                        state    <= IDLE;
                        gnt0_o   <= 1'b0;
                        gnt1_o   <= 1'b0;
                        hold_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances).
module tb_mem_arbiter;

    logic clk;
    logic rst_i;
    int   checks;
    int   failures;

    // MEM_LAT=1 instance signals
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, ack0, gnt1, ack1, mem_en, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    // MEM_LAT=3 instance signals (port 1 tied idle)
    logic        req3;
    logic [31:0] addr3;
    logic        gnt0_3, ack0_3, gnt1_3, ack1_3, mem_en3, mem_we3;
    logic [31:0] rdata0_3, rdata1_3, mem_addr3, mem_wdata3;
    logic [31:0] p0, p1, p2;

    logic [31:0] mem [0:15] = '{4: 32'h0000_00AB, 8: 32'h0000_0077, default: 32'h0};
    logic [31:0] rd_q;

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1), .MAX_HOLD(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .gnt0_o(gnt0), .ack0_o(ack0), .rdata0_o(rdata0),
        .gnt1_o(gnt1), .ack1_o(ack1), .rdata1_o(rdata1),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3), .MAX_HOLD(4)) dut3 (
        .clk_i(clk), .rst_i(rst_i),
        .req0_i(req3), .we0_i(1'b0), .addr0_i(addr3), .wdata0_i(32'h0),
        .req1_i(1'b0), .we1_i(1'b0), .addr1_i(32'h0), .wdata1_i(32'h0),
        .gnt0_o(gnt0_3), .ack0_o(ack0_3), .rdata0_o(rdata0_3),
        .gnt1_o(gnt1_3), .ack1_o(ack1_3), .rdata1_o(rdata1_3),
        .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3),
        .mem_wdata_o(mem_wdata3), .mem_rdata_i(p2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: command sampled on the rising edge, read data valid one cycle later.
    always @(posedge clk) begin
        if (mem_en && mem_we)  mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_en && !mem_we) rd_q <= mem[mem_addr[5:2]];
    end
    assign mem_rdata = rd_q;

    // Three-stage memory model: contents are 0xC0DE in the top half, address in the bottom.
    always @(posedge clk) begin
        if (mem_en3 && !mem_we3) p0 <= {16'hC0DE, mem_addr3[15:0]};
        p1 <= p0;
        p2 <= p1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Both ports request from IDLE; each drops its request on its own ack.
    task automatic round(input logic first);
        logic [1:0] oh_first;
        logic [1:0] oh_second;
        oh_first  = first ? 2'b10 : 2'b01;
        oh_second = first ? 2'b01 : 2'b10;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        chk("round_first_gnt", {gnt1, gnt0}, oh_first);
        tick();
        tick();
        chk("round_first_ack", {ack1, ack0}, oh_first);
        if (first) req1 = 1'b0; else req0 = 1'b0;
        tick();
        chk("round_swap_gnt", {gnt1, gnt0, mem_en}, {oh_second, 1'b1});
        tick();
        tick();
        chk("round_second_ack", {ack1, ack0}, oh_second);
        chk("round_rdata", {rdata1, rdata0}, {32'h77, 32'h55});
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("round_idle", {gnt1, gnt0}, 2'b00);
    endtask

    initial begin
        int  n0;
        bit  seen1;
        bit  idle_seen;
        checks = 0; failures = 0;
        rst_i = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        req3 = 1'b0; addr3 = '0;
        tick();
        tick();
        chk("reset_ctrl", {gnt0, gnt1, ack0, ack1, mem_en, mem_we}, 6'b0);
        chk("reset_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
        chk("reset_rdata", {rdata0, rdata1}, 64'h0);
        rst_i = 1'b1;
        tick();

        // Single read at 0x10; address change after the latching edge must be ignored.
        req0 = 1'b1; addr0 = 32'h10;
        tick();
        chk("rd_issue", {gnt0, gnt1, mem_en, mem_we}, 4'b1010);
        chk("rd_addr", mem_addr, 32'h10);
        addr0 = 32'h20;
        tick();
        chk("rd_wait", {mem_en, ack0}, 2'b00);
        tick();
        chk("rd_ack", {ack0, ack1}, 2'b10);
        chk("rd_data", rdata0, 32'hAB);
        req0 = 1'b0; addr0 = 32'h10;
        tick();
        chk("rd_done", {ack0, gnt0, gnt1}, 3'b000);

        // Write from port 1 to an unaligned address.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h13; wdata1 = 32'h55;
        tick();
        chk("wr_issue", {gnt1, gnt0, mem_en, mem_we}, 4'b1011);
        chk("wr_addr_data", {mem_addr, mem_wdata}, {32'h10, 32'h55});
        tick();
        chk("wr_we_pulse", {mem_en, mem_we}, 2'b00);
        tick();
        chk("wr_ack", {ack1, ack0}, 2'b10);
        chk("wr_rdata_kept", {rdata1, rdata0}, {32'h0, 32'hAB});
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'h20;
        tick();
        chk("wr_done", {ack1, gnt1}, 2'b00);

        // Two rounds of simultaneous requests.
        round(1'b0);
`ifdef MEM_ARB_RR_EN
        round(1'b1);
`else
        round(1'b0);
`endif

        // Hold limit: port 0 gets MAX_HOLD back-to-back transactions, then a direct swap.
        n0 = 0; seen1 = 1'b0; idle_seen = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 40 && !seen1; i++) begin
            tick();
            if (ack0) n0++;
            if (ack1) seen1 = 1'b1;
            if (!gnt0 && !gnt1) idle_seen = 1'b1;
        end
        chk("hold_ack0_count", n0, 4);
        chk("hold_port1_served", seen1, 1'b1);
        chk("hold_no_idle", idle_seen, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("hold_done", {gnt1, gnt0}, 2'b00);

        // Reset asserted while in WAIT.
        req0 = 1'b1; addr0 = 32'h10;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_wait_ctrl", {gnt0, gnt1, ack0, ack1, mem_en, mem_we}, 6'b0);
        chk("rst_wait_data", {mem_addr, rdata0}, 64'h0);
        tick();
        chk("rst_wait_noack", {ack0, gnt0}, 2'b00);
        rst_i = 1'b1;
        tick();
        chk("post_rst_issue", {gnt0, mem_en}, 2'b11);
        tick();
        tick();
        chk("post_rst_ack", ack0, 1'b1);
        chk("post_rst_data", rdata0, 32'h55);
        req0 = 1'b0;
        tick();

        // MEM_LAT=3 instance: single read.
        req3 = 1'b1; addr3 = 32'h24;
        tick();
        chk("lat3_issue", {gnt0_3, gnt1_3, mem_en3, mem_we3}, 4'b1010);
        chk("lat3_cmd", {mem_addr3, mem_wdata3}, {32'h24, 32'h0});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lat3_no_ack_yet", {ack0_3, ack1_3}, 2'b00);
        end
        tick();
        chk("lat3_ack", {ack0_3, ack1_3}, 2'b10);
        chk("lat3_data", {rdata0_3, rdata1_3}, {32'hC0DE_0024, 32'h0});
        req3 = 1'b0;
        tick();
        chk("lat3_done", {ack0_3, gnt0_3}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data width.
- REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.
- REQ-003 The block SHALL have parameter MEM_LAT, default 1, legal range 1..4, meaning cycles from memory-enable sample to valid mem_rdata_i.
- REQ-004 The block SHALL have parameter MAX_HOLD, default 4, legal range 1..15, meaning back-to-back transactions one requester may take while the other waits.
- REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
- REQ-006 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
- REQ-007 The block SHALL have ports reqN_i (input, 1), weN_i (input, 1), addrN_i (input, ADDR_W) and wdataN_i (input, DATA_W), for N=0 (CPU) and N=1 (debug/DMA): request, write enable, address and write data.
- REQ-008 The block SHALL have ports gntN_o (output, 1), ackN_o (output, 1) and rdataN_o (output, DATA_W), for N=0 and N=1: grant, completion pulse and read data.
- REQ-009 The block SHALL have ports mem_en_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, ADDR_W) and mem_wdata_o (output, DATA_W): memory command.
- REQ-010 The block SHALL have port mem_rdata_i, input, DATA_W: memory read data.

Function
- REQ-011 The block SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
- REQ-012 IDLE SHALL transition to ISSUE on any reqN_i; the selected winner's weN/addrN/wdataN SHALL be latched at that edge and its gntN_o set.
- REQ-013 In ISSUE (exactly 1 cycle), mem_en_o=1, with mem_we_o, mem_addr_o and mem_wdata_o driven from the latch; in every other state mem_en_o=0 and mem_we_o=0.
- REQ-014 WAIT SHALL last MEM_LAT cycles, counted by a down-counter; at its final edge mem_rdata_i SHALL be captured into the winner's rdataN_o.
- REQ-015 In RESP (1 cycle), ackN_o=1 for the winner only; ack is a single-cycle pulse, and ack=1 with we=1 also pulses on writes.
- REQ-016 Latency: a request sampled at edge E SHALL produce ack in cycle E+2+MEM_LAT; with MEM_LAT=1, ack falls in the 3rd cycle after E.
- REQ-017 Requesters SHALL hold req/we/addr/wdata stable until ack; changes after the latching edge SHALL be ignored.
- REQ-018 RESP exit SHALL go to ISSUE for the same winner if it still requests and either the hold count is below MAX_HOLD or the other requester is idle; otherwise, if the other requester is requesting, to ISSUE with that requester, re-latching and swapping gnt in the same edge; otherwise to IDLE with gnt cleared.
- REQ-019 The hold count SHALL reset to 1 on every grant change.
- REQ-020 Arbitration among simultaneous requests in IDLE SHALL follow REQ-028/REQ-029.
- REQ-021 mem_addr_o[1:0] SHALL be forced to 0 (word aligned).
- REQ-022 rdataN_o SHALL retain its last captured value until the next read completion for that port; write completions SHALL leave it unchanged.
- REQ-023 At most one gntN_o SHALL be high in any cycle.

Reset
- REQ-024 rst_i=0 SHALL, asynchronously, set: state=IDLE; gnt0_o=gnt1_o=0; ack0_o=ack1_o=0; mem_en_o=mem_we_o=0; mem_addr_o, mem_wdata_o and rdataN_o = 0; hold count = 0; RR pointer = 0.
- REQ-025 Reset asserted mid-transaction (ISSUE, WAIT or RESP) SHALL abort the transaction with no ack issued, and the first post-reset request SHALL start fresh.
- REQ-026 Reset release SHALL take effect on the first rising clk_i edge after rst_i=1.

Configuration
- REQ-027 The feature macro SHALL be MEM_ARB_RR_EN.
- REQ-028 With MEM_ARB_RR_EN defined, simultaneous IDLE requests SHALL be granted to the port named by a 1-bit round-robin pointer, and the pointer SHALL flip to the non-winner on each IDLE grant.
- REQ-029 Without MEM_ARB_RR_EN, port 0 SHALL have fixed priority in IDLE and the pointer SHALL not exist; MAX_HOLD fairness in RESP SHALL still apply.

Structure
- REQ-030 A shared package mem_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT/RESP), the port-index constants (PORT_CPU=0, PORT_DBG=1) and the MEM_LAT/MAX_HOLD range-check constants.
- REQ-031 One sub-module, arb_pick, SHALL be used: combinational 2-way pick from req vector and pointer, returning the one-hot grant.

Verification
- REQ-032 Single read: mem holds 0x0000_00AB at 0x10; req0 with addr 0x10, MEM_LAT=1 -> gnt0 next cycle, mem_en one cycle, ack0 3 cycles after sampling, rdata0_o=0xAB.
- REQ-033 Write: req1 with we=1, addr 0x13, wdata 0x55 -> mem_addr_o=0x10, mem_we_o=1 for one cycle, ack1 pulse, rdata1_o unchanged.
- REQ-034 Simultaneous requests, RR enabled: req0 and req1 both high from reset -> order 0,1,0,1 over four transactions; with the macro off -> 0 served first every time in IDLE.
- REQ-035 Hold limit: req0 continuous, req1 high, MAX_HOLD=4 -> exactly 4 acks to port 0, then a direct RESP->ISSUE swap to port 1 with no IDLE cycle.
- REQ-036 Reset in WAIT: rst_i low for 1 cycle -> no ack, all outputs 0 immediately; the next req0 completes normally in 2+MEM_LAT cycles.
- REQ-037 MEM_LAT=3: single read -> ack in cycle E+5, data matches the memory model.
